// File: rtl/jtbubl_shared_ram_pkg.sv
// Shared definitions for the N-port time-shared work RAM: ownership type,
// arbitration mode encodings and the per-port bus slicing helper.
package jtbubl_shared_ram_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int OWN_W     = 2;

    typedef logic [OWN_W-1:0] own_t;

    // Port i of a flattened bus occupies [slice_lo(i, width) +: width]
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/jtbubl_arb_rr.sv
// Ownership arbiter for the shared RAM: an owner keeps the RAM while its cs
// stays high; otherwise the next requester is chosen by fixed priority or RR.
module jtbubl_arb_rr
    import jtbubl_shared_ram_pkg::*;
#(
    parameter int NP = 2,
    parameter int RR = ARB_FIXED
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NP-1:0] cs,
    output own_t          owner,
    output logic          owner_vld
);

    own_t ptr;
    own_t win;
    own_t win_nxt;
    logic found;
    logic keep;
    logic any_req;

    always_comb begin
        keep    = 1'b0;
        found   = 1'b0;
        win     = '0;
        any_req = |cs;
        for (int i = 0; i < NP; i++) begin
            if (owner == own_t'(i) && cs[i]) keep = 1'b1;
        end
        keep = keep & owner_vld;
        // Round-robin: first look at or after the pointer, then wrap from 0
        if (RR == ARB_RR) begin
            for (int i = 0; i < NP; i++) begin
                if (!found && cs[i] && own_t'(i) >= ptr) begin
                    win   = own_t'(i);
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (!found && cs[i]) begin
                win   = own_t'(i);
                found = 1'b1;
            end
        end
        win_nxt = (int'(win) == NP-1) ? '0 : win + own_t'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            owner_vld <= 1'b0;
            ptr       <= '0;
        end else if (!keep) begin
            if (any_req) begin
                owner     <= win;
                owner_vld <= 1'b1;
                if (RR == ARB_RR) ptr <= win_nxt;
            end else begin
                owner_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtframe_ram.sv
// Single-port synchronous RAM, registered read (read-before-write).
// Contents are never initialised or cleared.
module jtframe_ram #(
    parameter int dw = 8,
    parameter int aw = 10
)(
    input  logic          clk,
    input  logic          cen,
    input  logic [dw-1:0] data,
    input  logic [aw-1:0] addr,
    input  logic          we,
    output logic [dw-1:0] q
);

    logic [dw-1:0] mem [0:(2**aw)-1];

    always_ff @(posedge clk) begin
        if (cen) begin
            q <= mem[addr];
            if (we) mem[addr] <= data;
        end
    end

endmodule

// File: rtl/jtbubl_shared_ram.sv
// N-port time-shared work RAM. The registered owner alone steers the RAM,
// so two CPUs can never reach it in the same cycle; losers wait on wait_n.
module jtbubl_shared_ram
    import jtbubl_shared_ram_pkg::*;
#(
    parameter int NP = 2,
    parameter int AW = 13,
    parameter int DW = 8,
    parameter int RR = ARB_FIXED
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NP-1:0]    cs,
    input  logic [NP-1:0]    we,
    input  logic [NP*AW-1:0] addr,
    input  logic [NP*DW-1:0] din,
    output logic [NP*DW-1:0] dout,
    output logic [NP-1:0]    wait_n,
    output logic [1:0]       owner,
    output logic             owner_vld
);

    logic          sel_cs;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_din;
    logic [DW-1:0] ram_q;
    logic          access;
    own_t          own_p1;
    logic          acc_p1;
    logic [NP-1:0] ready;

    jtbubl_arb_rr #(.NP(NP), .RR(RR)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .owner     (owner),
        .owner_vld (owner_vld)
    );

    // Stage 0: owner-steered RAM request
    always_comb begin
        sel_cs   = 1'b0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int i = 0; i < NP; i++) begin
            if (owner == own_t'(i)) begin
                sel_cs   = cs[i];
                sel_we   = we[i];
                sel_addr = addr[slice_lo(i, AW) +: AW];
                sel_din  = din[slice_lo(i, DW) +: DW];
            end
        end
    end

    assign access = owner_vld & sel_cs;

    jtframe_ram #(.dw(DW), .aw(AW)) u_ram (
        .clk  (clk),
        .cen  (access),
        .data (sel_din),
        .addr (sel_addr),
        .we   (access & sel_we),
        .q    (ram_q)
    );

    // Stage 1: RAM output captured for the port that owned the previous cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_p1 <= '0;
            acc_p1 <= 1'b0;
            ready  <= '0;
            dout   <= '0;
        end else begin
            own_p1 <= owner;
            acc_p1 <= access;
            for (int i = 0; i < NP; i++) begin
                if (acc_p1 && own_p1 == own_t'(i) && cs[i]) begin
                    dout[slice_lo(i, DW) +: DW] <= ram_q;
                    ready[i] <= 1'b1;
                end else if (!cs[i]) begin
                    ready[i] <= 1'b0;
                end
            end
        end
    end

    assign wait_n = ~cs | ready;

endmodule

// File: tb/tb_jtbubl_shared_ram.sv
// Bench for jtbubl_shared_ram: a 2-port fixed-priority and a 4-port round-robin
// instance, driven by CPU-like access tasks and checked by a scoreboard.
module tb_jtbubl_shared_ram;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Per-instance CPU stimulus: index 0 = 2-port DUT, 1 = 4-port DUT
    logic        c_cs   [2][4];
    logic        c_we   [2][4];
    logic [12:0] c_addr [2][4];
    logic [7:0]  c_din  [2][4];

    logic [1:0]  cs2, we2, wait2;
    logic [25:0] addr2;
    logic [15:0] din2, dout2;
    logic [1:0]  own2;
    logic        ov2;
    logic [3:0]  cs4, we4, wait4;
    logic [51:0] addr4;
    logic [31:0] din4, dout4;
    logic [1:0]  own4;
    logic        ov4;

    logic [3:0]  w_all [2];
    logic [31:0] d_all [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            cs2[p] = c_cs[0][p];
            we2[p] = c_we[0][p];
            addr2[p*13 +: 13] = c_addr[0][p];
            din2[p*8 +: 8] = c_din[0][p];
        end
        for (int p = 0; p < 4; p++) begin
            cs4[p] = c_cs[1][p];
            we4[p] = c_we[1][p];
            addr4[p*13 +: 13] = c_addr[1][p];
            din4[p*8 +: 8] = c_din[1][p];
        end
        w_all[0] = {2'b11, wait2};
        w_all[1] = wait4;
        d_all[0] = {16'h0, dout2};
        d_all[1] = dout4;
    end

    jtbubl_shared_ram #(.NP(2), .AW(13), .DW(8), .RR(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cs(cs2), .we(we2), .addr(addr2), .din(din2),
        .dout(dout2), .wait_n(wait2), .owner(own2), .owner_vld(ov2)
    );

    jtbubl_shared_ram #(.NP(4), .AW(13), .DW(8), .RR(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cs(cs4), .we(we4), .addr(addr4), .din(din4),
        .dout(dout4), .wait_n(wait4), .owner(own4), .owner_vld(ov4)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model: plain byte memory per instance, expected reads per port
    logic [7:0]  mm   [2][8192];
    logic [7:0]  expq [2][4][$];
    logic [12:0] wlist [4][$];

    task automatic access(input int d, input int p, input bit w, input logic [12:0] a,
                          input logic [7:0] v, input int hold, input bit now, output int lat);
        if (!now) begin
            @(negedge clk); #1;
        end
        c_we[d][p]   = w;
        c_addr[d][p] = a;
        c_din[d][p]  = v;
        c_cs[d][p]   = 1'b1;
        if (w) mm[d][a] = v;
        else expq[d][p].push_back(mm[d][a]);
        for (lat = 0; lat <= 40; lat++) begin
            @(negedge clk); #1;
            if (w_all[d][p]) break;
        end
        repeat (hold) begin
            @(negedge clk); #1;
        end
        c_cs[d][p] = 1'b0;
    endtask

    // Monitor: a read completes on the first sample with cs and wait_n high
    bit done [2][4];
    initial begin
        logic [7:0] e;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 4; p++) done[d][p] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < ((d == 0) ? 2 : 4); p++) begin
                    if (!c_cs[d][p]) begin
                        done[d][p] = 1'b0;
                    end else if (w_all[d][p] && !done[d][p] && rst_n) begin
                        done[d][p] = 1'b1;
                        if (!c_we[d][p]) begin
                            if (expq[d][p].size() == 0) begin
                                check("sb_underflow", 1, 0);
                            end else begin
                                e = expq[d][p].pop_front();
                                check($sformatf("rd_data_d%0d_p%0d", d, p),
                                      int'(d_all[d][p*8 +: 8]), int'(e));
                            end
                        end
                    end
                end
            end
        end
    end

    // Grant recorder for the 4-port instance: owner sequence and idle gaps
    bit         rec_on = 1'b0;
    logic [1:0] rec_q [$];
    int         gaps;
    initial begin
        logic [1:0] lo;
        bit lv;
        lv = 1'b0; lo = '0; gaps = 0;
        forever begin
            @(negedge clk);
            if (!rec_on) begin
                rec_q.delete();
                gaps = 0;
                lv = 1'b0;
            end else if (ov4) begin
                if (!lv || own4 != lo) rec_q.push_back(own4);
                lo = own4;
                lv = 1'b1;
            end else begin
                if (lv) gaps++;
                lv = 1'b0;
            end
        end
    end

    task automatic check_order(input string nm, input int o0, input int o1, input int o2, input int o3, input int n);
        int exp_o [4];
        exp_o = '{o0, o1, o2, o3};
        check({nm, "_len"}, rec_q.size(), n);
        for (int k = 0; k < n && k < rec_q.size(); k++)
            check($sformatf("%s_%0d", nm, k), int'(rec_q[k]), exp_o[k]);
        check({nm, "_gaps"}, gaps, 0);
    endtask

    task automatic rnd_port(input int p, input bit en, output int lat);
        bit w;
        logic [12:0] a;
        lat = -1;
        if (en) begin
            w = (wlist[p].size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (w) begin
                a = {2'(p), 11'($urandom)};
                wlist[p].push_back(a);
            end else begin
                a = wlist[p][$urandom_range(0, wlist[p].size() - 1)];
            end
            access(1, p, w, a, 8'($urandom), 0, 1'b0, lat);
        end
    endtask

    initial begin
        int la, lb, lc, ld;
        int lr [4];
        logic [3:0] sel;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 4; p++) begin
                c_cs[d][p] = 1'b0; c_we[d][p] = 1'b0;
                c_addr[d][p] = '0; c_din[d][p] = '0;
            end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ov2", int'(ov2), 0);
        check("rst_own2", int'(own2), 0);
        check("rst_dout2", int'(dout2), 0);
        check("rst_wait2", int'(wait2), 3);
        check("rst_ov4", int'(ov4), 0);
        check("rst_dout4", int'(dout4), 0);
        #1 rst_n = 1'b1;

        // Single uncontended write then read-back from the other port
        access(0, 0, 1'b1, 13'h0123, 8'h5A, 0, 1'b0, la);
        check("single_wr_lat", la, 2);
        access(0, 1, 1'b0, 13'h0123, 8'h00, 0, 1'b0, lb);
        check("single_rd_lat", lb, 2);

        // Simultaneous requests, fixed priority: port1 waits out port0
        fork
            access(0, 0, 1'b1, 13'h0200, 8'h33, 0, 1'b0, la);
            access(0, 1, 1'b0, 13'h0123, 8'h00, 0, 1'b0, lb);
        join
        check("contend_lat0", la, 2);
        check("contend_lat1", lb, 5);

        // Port1 abandons its request before being granted
        access(0, 1, 1'b1, 13'h0400, 8'h77, 0, 1'b0, la);
        access(0, 1, 1'b0, 13'h0200, 8'h00, 0, 1'b0, lb);
        fork
            access(0, 0, 1'b1, 13'h0300, 8'h11, 4, 1'b0, la);
            begin
                repeat (3) @(negedge clk);
                #1;
                c_we[0][1] = 1'b1; c_addr[0][1] = 13'h0400; c_din[0][1] = 8'hEE;
                c_cs[0][1] = 1'b1;
                @(negedge clk);
                check("abort_wait_low", int'(wait2[1]), 0);
                #1 c_cs[0][1] = 1'b0;
                #1 check("abort_wait_high", int'(wait2[1]), 1);
                check("abort_dout1", int'(dout2[15:8]), 8'h33);
            end
        join
        access(0, 1, 1'b0, 13'h0400, 8'h00, 0, 1'b0, lb);

        // Reset pulsed mid-write
        @(negedge clk); #1;
        c_we[0][0] = 1'b1; c_addr[0][0] = 13'h0500; c_din[0][0] = 8'h99; c_cs[0][0] = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ov", int'(ov2), 0);
        check("midrst_own", int'(own2), 0);
        check("midrst_dout", int'(dout2), 0);
        check("midrst_wait", int'(wait2), 2);
        @(negedge clk); #1 rst_n = 1'b1;
        for (lc = 0; lc <= 40; lc++) begin
            @(negedge clk); #1;
            if (lc == 0) check("midrst_regrant", int'(ov2), 1);
            if (wait2[0]) break;
        end
        check("midrst_lat", lc, 2);
        c_cs[0][0] = 1'b0;

        // Round-robin: all four request together, twice; pointer wraps to 0
        for (int r = 0; r < 2; r++) begin
            @(negedge clk); #1 rec_on = 1'b1;
            fork
                access(1, 0, 1'b1, 13'h0010, 8'h40, 0, 1'b0, lr[0]);
                access(1, 1, 1'b1, 13'h0811, 8'h41, 0, 1'b0, lr[1]);
                access(1, 2, 1'b1, 13'h1012, 8'h42, 0, 1'b0, lr[2]);
                access(1, 3, 1'b1, 13'h1813, 8'h43, 0, 1'b0, lr[3]);
            join
            rec_on = 1'b0;
            check_order($sformatf("rr_round%0d", r), 0, 1, 2, 3, 4);
            for (int p = 0; p < 4; p++) check($sformatf("rr_lat%0d_%0d", r, p), lr[p], 2 + 3*p);
        end

        // Lone port2 grant moves the pointer to 3; next full round starts there
        access(1, 2, 1'b1, 13'h1020, 8'h52, 0, 1'b0, la);
        @(negedge clk); #1 rec_on = 1'b1;
        fork
            access(1, 0, 1'b0, 13'h0010, 8'h00, 0, 1'b0, lr[0]);
            access(1, 1, 1'b0, 13'h0811, 8'h00, 0, 1'b0, lr[1]);
            access(1, 2, 1'b0, 13'h1012, 8'h00, 0, 1'b0, lr[2]);
            access(1, 3, 1'b0, 13'h1813, 8'h00, 0, 1'b0, lr[3]);
        join
        rec_on = 1'b0;
        check_order("rr_ptr3", 3, 0, 1, 2, 4);
        check("rr_ptr3_lat3", lr[3], 2);
        check("rr_ptr3_lat2", lr[2], 11);

        // Back-to-back hand-over from port0 to port2 with no idle cycle
        @(negedge clk); #1 rec_on = 1'b1;
        access(1, 0, 1'b1, 13'h0030, 8'h60, 0, 1'b0, la);
        access(1, 2, 1'b0, 13'h1020, 8'h00, 0, 1'b1, lb);
        rec_on = 1'b0;
        check_order("handover", 0, 2, 0, 0, 2);
        check("handover_lat0", la, 2);
        check("handover_lat2", lb, 2);

        // Random traffic, one region per port so the model stays order-free
        for (int r = 0; r < 15; r++) begin
            sel = 4'($urandom_range(1, 15));
            fork
                rnd_port(0, sel[0], la);
                rnd_port(1, sel[1], lb);
                rnd_port(2, sel[2], lc);
                rnd_port(3, sel[3], ld);
            join
            lr = '{la, lb, lc, ld};
            for (int p = 0; p < 4; p++)
                if (sel[p]) check("rnd_lat_in_2_11", int'(lr[p] >= 2 && lr[p] <= 11), 1);
        end

        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 4; p++)
                check($sformatf("sb_drain_d%0d_p%0d", d, p), expq[d][p].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtbubl_shared_ram.md
Name: jtbubl_shared_ram

Overview:
- N-port time-shared work RAM with wait-state arbitration.
- Generalises the main/sub shared work-RAM scheme (per-CPU "drives" flags plus wait_n gating) to NP CPU ports, parametrised address/data width, and a selectable fixed-priority or round-robin mode.
- Sits between the CPU address decoders and one internal synchronous RAM; drives each CPU's RAM-wait contribution and read data.

Parameters:
- NP, 2, number of CPU ports (2..4).
- AW, 13, address width in bits; RAM depth is 2^AW bytes.
- DW, 8, data width in bits.
- RR, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cs  in  NP  per-port access request; held for the whole CPU access.
- we  in  NP  per-port write enable, qualified by cs.
- addr  in  NP*AW  per-port address; port i occupies bits [i*AW +: AW].
- din  in  NP*DW  per-port write data; port i occupies bits [i*DW +: DW].
- dout  out  NP*DW  per-port read data, registered.
- wait_n  out  NP  per-port wait; low stalls that CPU.
- owner  out  2  index of the current owner (debug).
- owner_vld  out  1  owner is valid (debug).

Behaviour:
- Reset (asynchronous): owner_vld=0, owner=0, ready=0 on all ports, dout=0, RR pointer=0. RAM contents are not cleared.
- wait_n[i] = ~cs[i] | ready[i], combinational. An idle port never waits.
- Arbitration, evaluated every clk edge:
  - If owner_vld and cs[owner]=1, keep the current owner.
  - Otherwise choose among ports with cs=1. RR=0: lowest index wins. RR=1: first requester at or after the pointer, wrapping modulo NP; pointer <= (winner+1) mod NP on each new grant.
  - With no requester, owner_vld <= 0.
- Hand-over: when the owner drops cs while another port requests, the new owner is latched on that same edge. No idle cycle.
- Pipeline for a granted port i (E1 = first edge with cs[i]=1 and no conflicting owner):
  - E1: owner <= i.
  - E2: RAM samples addr[i]. If we[i], the write of din[i] occurs at E2 and on every further owned edge; the last value wins. The owner index is delayed one stage (own_d).
  - E3: dout[i] <= RAM q, ready[i] <= 1.
  - Uncontended access: wait_n low for 2 clk cycles after cs rises.
- dout[i] reloads on every edge where own_d==i and cs[i]=1. It holds its last value otherwise.
- ready[i] clears on the edge after cs[i] falls. It never asserts for a port that lost ownership.
- Contention: a losing port keeps wait_n low until it is granted. Its access then follows the E1..E3 pipeline relative to its grant edge.
- cs dropped before grant: no RAM read or write, dout unchanged.
- Simultaneous arrival of all NP requests:
  - RR=0: order 0,1,...
  - RR=1: order starts at the pointer.
- Reset asserted mid-access: everything clears immediately and wait_n[i]=~cs[i]. If cs is still high at reset release, arbitration restarts from E1 and any interrupted write may be incomplete.
- RAM ports never see two writers in one cycle; the address/data/we mux is driven solely by the registered owner.

Decomposition:
- Shared package holds:
  - port-slice helper constants (AW/DW slicing);
  - arbitration mode encodings (ARB_FIXED=0, ARB_RR=1);
  - ownership width (2 bits, NP<=4).
- One sub-module: jtbubl_arb_rr. It is a purely sequential arbiter producing owner, owner_vld and the pointer from cs.
- RAM instance is the existing jtframe_ram with aw=AW.

Test Plan:
- Single access, NP=2: port0 cs=1, we=1, addr=0x0123, din=0x5A for 4 cycles → wait_n[0] low exactly 2 cycles; mem[0x0123]=0x5A. Read back from port1 → dout[1]=0x5A at E3.
- Simultaneous cs on ports 0 and 1, RR=0 → port0 owns first; port1 granted on the edge port0 drops cs; wait_n[1] stays low throughout port0's access plus 2 cycles.
- RR=1, NP=4, all four request repeatedly for 1-cycle-after-ready accesses → grant order 0,1,2,3,0 and pointer wraps to 0.
- Port1 raises cs then drops it before grant while port0 owns → no write to port1's address, dout[1] unchanged, wait_n[1]=1 once cs is low.
- rst_n pulsed low during a port0 write at E2 → owner_vld=0, ready=0, dout=0 immediately. With cs[0] held, re-grant at the first edge after release and wait_n[0] high 2 cycles later.
- Back-to-back hand-over: port0 releases and port2 requests in the same cycle → owner=2 on the next edge with no idle cycle; owner_vld never deasserts.
